unidade_controle: RTL and testbench

- Multicycle control FSM for the RV32I datapath.
- Drives the 4-bit `estado` bus consumed by the instruction fetch block, which loads `instrucao <= instrucoes[PC]` on the clock edge that ends state 0000.
- Decodes the opcode, funct3 and funct7[5] of the fetched instruction and sequences PC update, register file, ALU and data memory.
- Handles a data-memory ready handshake, halts on illegal or all-zero instructions, and counts retired instructions.

---
 rtl/unidade_controle.sv | 164 ++++++++++++++++
 tb/tb_unidade_controle.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Multicycle control FSM for the RV32I datapath: sequences fetch, decode, ALU,
// memory and branch steps, halts on illegal opcodes and counts retired instructions.
module unidade_controle #(
    parameter int LARGURA_CONT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              opcode,
    input  logic [2:0]              funct3,
    input  logic                    funct7_5,
    input  logic                    zero,
    input  logic                    mem_pronta,
    output logic [3:0]              estado,
    output logic                    pc_write,
    output logic                    pc_sel,
    output logic                    reg_write,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    mem_to_reg,
    output logic                    alu_src,
    output logic [3:0]              alu_op,
    output logic                    parado,
    output logic [LARGURA_CONT-1:0] cont_instr
);

    typedef enum logic [3:0] {
        FETCH    = 4'b0000,
        DECODE   = 4'b0001,
        MEMADDR  = 4'b0010,
        MEMREAD  = 4'b0011,
        MEMWB    = 4'b0100,
        MEMWRITE = 4'b0101,
        EXEC_R   = 4'b0110,
        ALU_WB   = 4'b0111,
        BRANCH   = 4'b1000,
        EXEC_I   = 4'b1001,
        HALT     = 4'b1010
    } estado_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    estado_t    est;
    logic [6:0] opcode_lat;
    logic [2:0] funct3_lat;
    logic       funct7_5_lat;
    logic       retira;

    // funct7_5 only selects SUB for R-type; I-type 101 is always SRL
    function automatic logic [3:0] decodifica_alu(input logic [2:0] f3, input logic f7,
                                                  input logic tipo_r);
        case (f3)
            3'b000:  decodifica_alu = (tipo_r && f7) ? ALU_SUB : ALU_ADD;
            3'b111:  decodifica_alu = ALU_AND;
            3'b110:  decodifica_alu = ALU_OR;
            3'b100:  decodifica_alu = ALU_XOR;
            3'b001:  decodifica_alu = ALU_SLL;
            3'b101:  decodifica_alu = ALU_SRL;
            3'b010:  decodifica_alu = ALU_SLT;
            default: decodifica_alu = ALU_ADD;
        endcase
    endfunction

    assign retira = (est == MEMWB) || (est == ALU_WB) || (est == BRANCH) ||
                    ((est == MEMWRITE) && mem_pronta);

    always_ff @(posedge clk) begin
        if (reset) begin
            est          <= FETCH;
            cont_instr   <= '0;
            opcode_lat   <= '0;
            funct3_lat   <= '0;
            funct7_5_lat <= 1'b0;
        end else begin
            if (retira)
                cont_instr <= cont_instr + 1'b1;
            case (est)
                FETCH:   est <= DECODE;
                DECODE: begin
                    opcode_lat   <= opcode;
                    funct3_lat   <= funct3;
                    funct7_5_lat <= funct7_5;
                    case (opcode)
                        OP_LW, OP_SW: est <= MEMADDR;
                        OP_R:         est <= EXEC_R;
                        OP_I:         est <= EXEC_I;
                        OP_BRANCH:    est <= BRANCH;
                        default:      est <= HALT;
                    endcase
                end
                MEMADDR:  est <= (opcode_lat == OP_LW) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (mem_pronta) est <= MEMWB;
                MEMWB:    est <= FETCH;
                MEMWRITE: if (mem_pronta) est <= FETCH;
                EXEC_R, EXEC_I: est <= (funct3_lat == 3'b011) ? HALT : ALU_WB;
                ALU_WB:   est <= FETCH;
                BRANCH:   est <= FETCH;
                HALT:     est <= HALT;
                default:  est <= HALT;
            endcase
        end
    end

    assign estado = est;

    always_comb begin
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        parado     = 1'b0;
        case (est)
            MEMADDR:  alu_src = 1'b1;
            MEMREAD:  mem_read = 1'b1;
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                pc_write   = 1'b1;
            end
            // PC advances only on the cycle the store completes
            MEMWRITE: begin
                mem_write = 1'b1;
                pc_write  = mem_pronta;
            end
            EXEC_R:   alu_op = decodifica_alu(funct3_lat, funct7_5_lat, 1'b1);
            EXEC_I: begin
                alu_src = 1'b1;
                alu_op  = decodifica_alu(funct3_lat, funct7_5_lat, 1'b0);
            end
            ALU_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
            end
            BRANCH: begin
                alu_op   = ALU_SUB;
                pc_write = 1'b1;
                case (funct3_lat)
                    3'b000:  pc_sel = zero;
                    3'b001:  pc_sel = ~zero;
                    default: pc_sel = 1'b0;
                endcase
            end
            HALT:     parado = 1'b1;
            default:  ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle: walks R, lw, sw, beq/bne, I-type, halt
// and reset-during-wait sequences against hand-computed control vectors.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        mem_pronta;
    logic [3:0]  estado;
    logic        pc_write, pc_sel, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [3:0]  alu_op;
    logic        parado;
    logic [31:0] cont_instr;

    int vetores = 0;
    int erros   = 0;

    unidade_controle #(.LARGURA_CONT(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .mem_pronta(mem_pronta), .estado(estado), .pc_write(pc_write),
        .pc_sel(pc_sel), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .alu_src(alu_src), .alu_op(alu_op), .parado(parado),
        .cont_instr(cont_instr)
    );

    always #5 clk = ~clk;

    // {estado, pc_write, pc_sel, reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op, parado}
    logic [15:0] obs_v;
    assign obs_v = {estado, pc_write, pc_sel, reg_write, mem_read, mem_write,
                    mem_to_reg, alu_src, alu_op, parado};

    function automatic logic [15:0] ev(input logic [3:0] e, input logic [6:0] c,
                                       input logic [3:0] op, input logic p);
        ev = {e, c, op, p};
    endfunction

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vetores++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: obtido %h esperado %h", tag, obs, esp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; mem_pronta = 1'b0;

        for (int i = 0; i < 3; i++) begin
            ciclo();
            verifica("reset_sinais", {16'h0, obs_v}, {16'h0, ev(4'h0, 7'b0, 4'h0, 1'b0)});
            verifica("reset_cont", cont_instr, 32'd0);
        end

        // R-type SUB
        reset = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        ciclo(); verifica("r_decode", {16'h0, obs_v}, {16'h0, ev(4'h1, 7'b0, 4'h0, 1'b0)});
        ciclo(); verifica("r_exec",   {16'h0, obs_v}, {16'h0, ev(4'h6, 7'b0, 4'h1, 1'b0)});
        funct3 = 3'b111; funct7_5 = 1'b0; #1;
        verifica("r_latch",  {16'h0, obs_v}, {16'h0, ev(4'h6, 7'b0, 4'h1, 1'b0)});
        ciclo(); verifica("r_wb",     {16'h0, obs_v}, {16'h0, ev(4'h7, 7'b1010000, 4'h0, 1'b0)});
        ciclo(); verifica("r_fetch",  {16'h0, obs_v}, {16'h0, ev(4'h0, 7'b0, 4'h0, 1'b0)});
        verifica("r_cont", cont_instr, 32'd1);

        // lw with three wait cycles
        opcode = 7'b0000011; funct3 = 3'b010; mem_pronta = 1'b0;
        ciclo(); verifica("lw_decode", {16'h0, obs_v}, {16'h0, ev(4'h1, 7'b0, 4'h0, 1'b0)});
        ciclo(); verifica("lw_addr",   {16'h0, obs_v}, {16'h0, ev(4'h2, 7'b0000001, 4'h0, 1'b0)});
        ciclo(); verifica("lw_read",   {16'h0, obs_v}, {16'h0, ev(4'h3, 7'b0001000, 4'h0, 1'b0)});
        for (int i = 0; i < 3; i++) begin
            ciclo(); verifica("lw_wait", {16'h0, obs_v}, {16'h0, ev(4'h3, 7'b0001000, 4'h0, 1'b0)});
        end
        mem_pronta = 1'b1;
        ciclo(); verifica("lw_wb",     {16'h0, obs_v}, {16'h0, ev(4'h4, 7'b1010010, 4'h0, 1'b0)});
        verifica("lw_cont_wb", cont_instr, 32'd1);
        mem_pronta = 1'b0;
        ciclo(); verifica("lw_cont", cont_instr, 32'd2);

        // sw with memory already ready
        opcode = 7'b0100011; mem_pronta = 1'b1;
        ciclo(); verifica("sw_decode", {16'h0, obs_v}, {16'h0, ev(4'h1, 7'b0, 4'h0, 1'b0)});
        ciclo(); verifica("sw_addr",   {16'h0, obs_v}, {16'h0, ev(4'h2, 7'b0000001, 4'h0, 1'b0)});
        ciclo(); verifica("sw_write",  {16'h0, obs_v}, {16'h0, ev(4'h5, 7'b1000100, 4'h0, 1'b0)});
        ciclo(); verifica("sw_fetch",  {16'h0, obs_v}, {16'h0, ev(4'h0, 7'b0, 4'h0, 1'b0)});
        verifica("sw_cont", cont_instr, 32'd3);
        mem_pronta = 1'b0;

        // beq
        opcode = 7'b1100011; funct3 = 3'b000; zero = 1'b1;
        ciclo(); ciclo();
        verifica("beq_z1", {16'h0, obs_v}, {16'h0, ev(4'h8, 7'b1100000, 4'h1, 1'b0)});
        zero = 1'b0; #1;
        verifica("beq_z0", {16'h0, obs_v}, {16'h0, ev(4'h8, 7'b1000000, 4'h1, 1'b0)});
        ciclo(); verifica("beq_cont", cont_instr, 32'd4);

        // bne
        funct3 = 3'b001; zero = 1'b1;
        ciclo(); ciclo();
        verifica("bne_z1", {16'h0, obs_v}, {16'h0, ev(4'h8, 7'b1000000, 4'h1, 1'b0)});
        zero = 1'b0; #1;
        verifica("bne_z0", {16'h0, obs_v}, {16'h0, ev(4'h8, 7'b1100000, 4'h1, 1'b0)});
        ciclo(); verifica("bne_cont", cont_instr, 32'd5);

        // I-type SRL (funct7_5 set) and ADD (funct7_5 ignored)
        opcode = 7'b0010011; funct3 = 3'b101; funct7_5 = 1'b1;
        ciclo(); ciclo();
        verifica("i_srl",  {16'h0, obs_v}, {16'h0, ev(4'h9, 7'b0000001, 4'h6, 1'b0)});
        ciclo(); verifica("i_wb", {16'h0, obs_v}, {16'h0, ev(4'h7, 7'b1010000, 4'h0, 1'b0)});
        ciclo();
        funct3 = 3'b000;
        ciclo(); ciclo();
        verifica("i_add",  {16'h0, obs_v}, {16'h0, ev(4'h9, 7'b0000001, 4'h0, 1'b0)});
        ciclo(); ciclo();
        verifica("i_cont", cont_instr, 32'd7);

        // reset while waiting on memory
        opcode = 7'b0000011; mem_pronta = 1'b0;
        ciclo(); ciclo(); ciclo();
        verifica("rst_wait_pre", {16'h0, obs_v}, {16'h0, ev(4'h3, 7'b0001000, 4'h0, 1'b0)});
        reset = 1'b1;
        ciclo();
        verifica("rst_wait", {16'h0, obs_v}, {16'h0, ev(4'h0, 7'b0, 4'h0, 1'b0)});
        verifica("rst_wait_cont", cont_instr, 32'd0);
        reset = 1'b0;

        // all-zero instruction halts until reset
        opcode = 7'b0000000; mem_pronta = 1'b1;
        ciclo(); ciclo();
        verifica("halt_entry", {16'h0, obs_v}, {16'h0, ev(4'hA, 7'b0, 4'h0, 1'b1)});
        for (int i = 0; i < 10; i++) begin
            ciclo(); verifica("halt_hold", {16'h0, obs_v}, {16'h0, ev(4'hA, 7'b0, 4'h0, 1'b1)});
        end
        verifica("halt_cont", cont_instr, 32'd0);
        reset = 1'b1;
        ciclo();
        verifica("halt_reset", {16'h0, obs_v}, {16'h0, ev(4'h0, 7'b0, 4'h0, 1'b0)});
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
